multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 79 +++++++
 rtl/mc_decode.sv | 37 +++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// funct codes, datapath select codes and the instruction class one-hot layout.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_IMMEX  = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;
    localparam logic [1:0] PCSRC_RS   = 2'b11;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] IMM_SIGN  = 2'b00;
    localparam logic [1:0] IMM_ZERO  = 2'b01;
    localparam logic [1:0] IMM_UPPER = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // Bit positions of the one-hot instruction class.
    localparam int CL_MEM   = 0;
    localparam int CL_RTYPE = 1;
    localparam int CL_BEQ   = 2;
    localparam int CL_IMM   = 3;
    localparam int CL_J     = 4;
    localparam int CL_JAL   = 5;
    localparam int CL_JR    = 6;
    localparam int CL_NONE  = 7;
    localparam int CL_W     = 8;

    typedef logic [CL_W-1:0] cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to a one-hot class plus the
// ALU operation for R-type arithmetic.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output cls_t       cls_o,
    output logic [2:0] r_alu_o
);

    always_comb begin
        cls_o   = '0;
        r_alu_o = ALU_ADD;
        case (op_i)
            OP_RTYPE: begin
                // nop (funct 0) falls into the default and retires in DECODE.
                case (funct_i)
                    FN_ADD: begin cls_o[CL_RTYPE] = 1'b1; r_alu_o = ALU_ADD; end
                    FN_SUB: begin cls_o[CL_RTYPE] = 1'b1; r_alu_o = ALU_SUB; end
                    FN_AND: begin cls_o[CL_RTYPE] = 1'b1; r_alu_o = ALU_AND; end
                    FN_OR:  begin cls_o[CL_RTYPE] = 1'b1; r_alu_o = ALU_OR;  end
                    FN_SLT: begin cls_o[CL_RTYPE] = 1'b1; r_alu_o = ALU_SLT; end
                    FN_JR:  cls_o[CL_JR] = 1'b1;
                    default: cls_o[CL_NONE] = 1'b1;
                endcase
            end
            OP_LW, OP_SW:            cls_o[CL_MEM] = 1'b1;
            OP_BEQ:                  cls_o[CL_BEQ] = 1'b1;
            OP_ADDI, OP_ORI, OP_LUI: cls_o[CL_IMM] = 1'b1;
            OP_J:                    cls_o[CL_J]   = 1'b1;
            OP_JAL:                  cls_o[CL_JAL] = 1'b1;
            default:                 cls_o[CL_NONE] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM: sequences fetch/decode/execute/writeback and drives
// the datapath selects, write enables and a per-instruction done strobe.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSel,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       done,
    output logic [3:0] state
);

    state_t     state_q, state_d, cur;
    logic       hold_q;
    logic       fetch_ok;
    cls_t       cls;
    logic [2:0] r_alu;
    logic       unused_zero;

    // The branch condition is applied in the datapath via PCWriteCond.
    assign unused_zero = zero;

    mc_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .cls_o   (cls),
        .r_alu_o (r_alu)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
        hold_q <= reset;
    end

    // While reset is high the outputs look like FETCH; in the cycle after reset
    // FETCH is stalled so that PCWrite/IRWrite stay low and the PC is not skipped.
    assign cur      = reset ? S_FETCH : state_q;
    assign fetch_ok = mem_ready & ~reset & ~hold_q;
    assign state    = cur;

    always_comb begin
        state_d     = cur;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUControl  = ALU_AND;
        ImmSel      = IMM_SIGN;
        RegWrite    = 1'b0;
        RegDst      = DST_RT;
        MemtoReg    = M2R_ALU;
        done        = 1'b0;
        case (cur)
            S_FETCH: begin
                ALUSrcB    = SRCB_4;
                ALUControl = ALU_ADD;
                if (fetch_ok) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_BR;
                ALUControl = ALU_ADD;
                if (cls[CL_MEM])        state_d = S_MEMADR;
                else if (cls[CL_RTYPE]) state_d = S_REX;
                else if (cls[CL_BEQ])   state_d = S_BEQ;
                else if (cls[CL_IMM])   state_d = S_IMMEX;
                else if (cls[CL_J])     state_d = S_JUMP;
                else if (cls[CL_JAL])   state_d = S_JAL;
                else if (cls[CL_JR])    state_d = S_JR;
                else begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ImmSel     = IMM_SIGN;
                ALUControl = ALU_ADD;
                state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                RegDst   = DST_RT;
                MemtoReg = M2R_MDR;
                done     = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_REX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUControl = r_alu;
                state_d    = S_ALUWB;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_ORI:  begin ImmSel = IMM_ZERO;  ALUControl = ALU_OR;  end
                    OP_LUI:  begin ImmSel = IMM_UPPER; ALUControl = ALU_OR;  end
                    default: begin ImmSel = IMM_SIGN;  ALUControl = ALU_ADD; end
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_ALU;
                RegDst   = cls[CL_RTYPE] ? DST_RD : DST_RT;
                done     = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_RT;
                ALUControl  = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = PCSRC_OUT;
                done        = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSrc    = PCSRC_JUMP;
                RegWrite = 1'b1;
                RegDst   = DST_RA;
                MemtoReg = M2R_PC;
                done     = 1'b1;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_RS;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full packed output vector against hand-derived values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       IorD, MemWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, RegWrite, done;
    logic [1:0] PCSrc, ALUSrcB, ImmSel, RegDst, MemtoReg;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSel(ImmSel), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .done(done), .state(state)
    );

    logic [24:0] outs;
    assign outs = {state, IorD, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSrc, ALUSrcA,
                   ALUSrcB, ALUControl, ImmSel, RegWrite, RegDst, MemtoReg, done};

    function automatic logic [24:0] ex(input logic [3:0] st, input logic iord, input logic mw,
        input logic irw, input logic pcw, input logic pcwc, input logic [1:0] pcsrc,
        input logic srca, input logic [1:0] srcb, input logic [2:0] alu, input logic [1:0] imm,
        input logic rw, input logic [1:0] rdst, input logic [1:0] m2r, input logic dn);
        return {st, iord, mw, irw, pcw, pcwc, pcsrc, srca, srcb, alu, imm, rw, rdst, m2r, dn};
    endfunction

    logic [24:0] f_go, f_wait, dec, dec_done;

    // Drive inputs, let combinational outputs settle, compare, then advance one clock.
    task automatic step(input string tag, input logic rst, input logic rdy, input logic [5:0] o,
                        input logic [5:0] f, input logic z, input logic [24:0] exp_v);
        reset = rst; mem_ready = rdy; op = o; funct = f; zero = z;
        #1;
        total++;
        assert (outs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%07h expected=%07h", tag, outs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        f_go     = ex(4'd0, 0,0,1,1,0, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0);
        f_wait   = ex(4'd0, 0,0,0,0,0, 2'b00, 0, 2'b01, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0);
        dec      = ex(4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0);
        dec_done = ex(4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 3'b010, 2'b00, 0, 2'b00, 2'b00, 1);

        @(posedge clk); #1;
        step("reset0", 1, 1, 6'd0, 6'd0, 0, f_wait);
        step("reset1", 1, 1, 6'd0, 6'd0, 0, f_wait);
        step("post_reset_hold", 0, 1, 6'd0, 6'd0, 0, f_wait);

        // add
        step("add_fetch", 0, 1, 6'd0, 6'b100000, 0, f_go);
        step("add_dec",   0, 1, 6'd0, 6'b100000, 0, dec);
        step("add_rex",   0, 1, 6'd0, 6'b100000, 0, ex(4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0));
        step("add_wb",    0, 1, 6'd0, 6'b100000, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b01, 2'b00, 1));
        // sub and slt execute codes
        step("sub_fetch", 0, 1, 6'd0, 6'b100010, 0, f_go);
        step("sub_dec",   0, 1, 6'd0, 6'b100010, 0, dec);
        step("sub_rex",   0, 1, 6'd0, 6'b100010, 0, ex(4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b110, 2'b00, 0, 2'b00, 2'b00, 0));
        step("sub_wb",    0, 1, 6'd0, 6'b100010, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b01, 2'b00, 1));
        step("slt_fetch", 0, 1, 6'd0, 6'b101010, 0, f_go);
        step("slt_dec",   0, 1, 6'd0, 6'b101010, 0, dec);
        step("slt_rex",   0, 1, 6'd0, 6'b101010, 0, ex(4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 3'b111, 2'b00, 0, 2'b00, 2'b00, 0));
        step("slt_wb",    0, 1, 6'd0, 6'b101010, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b01, 2'b00, 1));

        // lw with one fetch wait and two MEMRD waits
        step("lw_fwait",  0, 0, 6'b100011, 6'd0, 0, f_wait);
        step("lw_fetch",  0, 1, 6'b100011, 6'd0, 0, f_go);
        step("lw_dec",    0, 1, 6'b100011, 6'd0, 0, dec);
        step("lw_adr",    0, 1, 6'b100011, 6'd0, 0, ex(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0));
        step("lw_rd_w0",  0, 0, 6'b100011, 6'd0, 0, ex(4'd3, 1,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0));
        step("lw_rd_w1",  0, 0, 6'b100011, 6'd0, 0, ex(4'd3, 1,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0));
        step("lw_rd",     0, 1, 6'b100011, 6'd0, 0, ex(4'd3, 1,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0));
        step("lw_wb",     0, 1, 6'b100011, 6'd0, 0, ex(4'd4, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b00, 2'b01, 1));

        // sw
        step("sw_fetch",  0, 1, 6'b101011, 6'd0, 0, f_go);
        step("sw_dec",    0, 1, 6'b101011, 6'd0, 0, dec);
        step("sw_adr",    0, 1, 6'b101011, 6'd0, 0, ex(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0));
        step("sw_wr",     0, 1, 6'b101011, 6'd0, 0, ex(4'd5, 1,1,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 1));

        // beq taken and not taken give identical control
        step("beq1_fetch", 0, 1, 6'b000100, 6'd0, 1, f_go);
        step("beq1_dec",   0, 1, 6'b000100, 6'd0, 1, dec);
        step("beq1_ex",    0, 1, 6'b000100, 6'd0, 1, ex(4'd8, 0,0,0,0,1, 2'b01, 1, 2'b00, 3'b110, 2'b00, 0, 2'b00, 2'b00, 1));
        step("beq0_fetch", 0, 1, 6'b000100, 6'd0, 0, f_go);
        step("beq0_dec",   0, 1, 6'b000100, 6'd0, 0, dec);
        step("beq0_ex",    0, 1, 6'b000100, 6'd0, 0, ex(4'd8, 0,0,0,0,1, 2'b01, 1, 2'b00, 3'b110, 2'b00, 0, 2'b00, 2'b00, 1));

        // jumps
        step("j_fetch",   0, 1, 6'b000010, 6'd0, 0, f_go);
        step("j_dec",     0, 1, 6'b000010, 6'd0, 0, dec);
        step("j_ex",      0, 1, 6'b000010, 6'd0, 0, ex(4'd10, 0,0,0,1,0, 2'b10, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 1));
        step("jal_fetch", 0, 1, 6'b000011, 6'd0, 0, f_go);
        step("jal_dec",   0, 1, 6'b000011, 6'd0, 0, dec);
        step("jal_ex",    0, 1, 6'b000011, 6'd0, 0, ex(4'd11, 0,0,0,1,0, 2'b10, 0, 2'b00, 3'b000, 2'b00, 1, 2'b10, 2'b10, 1));
        step("jr_fetch",  0, 1, 6'd0, 6'b001000, 0, f_go);
        step("jr_dec",    0, 1, 6'd0, 6'b001000, 0, dec);
        step("jr_ex",     0, 1, 6'd0, 6'b001000, 0, ex(4'd12, 0,0,0,1,0, 2'b11, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 1));

        // immediates
        step("addi_fetch", 0, 1, 6'b001000, 6'd0, 0, f_go);
        step("addi_dec",   0, 1, 6'b001000, 6'd0, 0, dec);
        step("addi_ex",    0, 1, 6'b001000, 6'd0, 0, ex(4'd9, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0));
        step("addi_wb",    0, 1, 6'b001000, 6'd0, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b00, 2'b00, 1));
        step("ori_fetch",  0, 1, 6'b001101, 6'd0, 0, f_go);
        step("ori_dec",    0, 1, 6'b001101, 6'd0, 0, dec);
        step("ori_ex",     0, 1, 6'b001101, 6'd0, 0, ex(4'd9, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b001, 2'b01, 0, 2'b00, 2'b00, 0));
        step("ori_wb",     0, 1, 6'b001101, 6'd0, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b00, 2'b00, 1));
        step("lui_fetch",  0, 1, 6'b001111, 6'd0, 0, f_go);
        step("lui_dec",    0, 1, 6'b001111, 6'd0, 0, dec);
        step("lui_ex",     0, 1, 6'b001111, 6'd0, 0, ex(4'd9, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b001, 2'b10, 0, 2'b00, 2'b00, 0));
        step("lui_wb",     0, 1, 6'b001111, 6'd0, 0, ex(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 1, 2'b00, 2'b00, 1));

        // nop, unknown op, unknown funct retire in DECODE
        step("nop_fetch",  0, 1, 6'd0, 6'd0, 0, f_go);
        step("nop_dec",    0, 1, 6'd0, 6'd0, 0, dec_done);
        step("unk_fetch",  0, 1, 6'b111111, 6'd0, 0, f_go);
        step("unk_dec",    0, 1, 6'b111111, 6'd0, 0, dec_done);
        step("unkf_fetch", 0, 1, 6'd0, 6'b111111, 0, f_go);
        step("unkf_dec",   0, 1, 6'd0, 6'b111111, 0, dec_done);

        // sw stalled in MEMWR, then reset
        step("swr_fetch", 0, 1, 6'b101011, 6'd0, 0, f_go);
        step("swr_dec",   0, 1, 6'b101011, 6'd0, 0, dec);
        step("swr_adr",   0, 1, 6'b101011, 6'd0, 0, ex(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 2'b00, 0, 2'b00, 2'b00, 0));
        step("swr_wait",  0, 0, 6'b101011, 6'd0, 0, ex(4'd5, 1,1,0,0,0, 2'b00, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0));
        step("swr_reset", 1, 0, 6'b101011, 6'd0, 0, f_wait);
        step("swr_after", 0, 1, 6'b101011, 6'd0, 0, f_wait);
        step("swr_resume", 0, 1, 6'b101011, 6'd0, 0, f_go);
        step("swr_dec2",  0, 1, 6'b101011, 6'd0, 0, dec);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
